// File: rtl/rv_pkg.sv
// Shared RV32I(M) decode definitions: opcodes, function codes, NOP, immediates, bundle.
package rv_pkg;

   localparam int unsigned RV_XLEN = 32;
   localparam int unsigned REG_AW  = 5;

   localparam logic [31:0] INST_NOP = 32'h00000013;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_JALR = 3'b000;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   typedef struct packed {
      logic [RV_XLEN-1:0] op1;
      logic [RV_XLEN-1:0] op2;
      logic [RV_XLEN-1:0] op1_jump;
      logic [RV_XLEN-1:0] op2_jump;
      logic [31:0]        inst;
      logic [RV_XLEN-1:0] inst_addr;
      logic [RV_XLEN-1:0] reg1_rdata;
      logic [RV_XLEN-1:0] reg2_rdata;
      logic [RV_XLEN-1:0] csr_rdata;
      logic [RV_XLEN-1:0] csr_waddr;
      logic               reg_we;
      logic [REG_AW-1:0]  reg_waddr;
      logic               csr_we;
      logic               illegal;
   } id_bundle_t;

   // Sign/zero-extended immediate of the requested format.
   function automatic logic [RV_XLEN-1:0] imm_gen(input logic [31:0] inst, input imm_type_e t);
      logic [RV_XLEN-1:0] imm;
      case (t)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // Output register contents after reset: a NOP with everything else cleared.
   function automatic id_bundle_t bundle_rst();
      id_bundle_t b;
      b      = '0;
      b.inst = INST_NOP;
      return b;
   endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I(M) decoder: instruction and operand data in, decoded bundle out.
module id_decode
   import rv_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0]         inst_i,
   input  logic [RV_XLEN-1:0]  inst_addr_i,
   input  logic [RV_XLEN-1:0]  rs1_data_i,
   input  logic [RV_XLEN-1:0]  rs2_data_i,
   input  logic [RV_XLEN-1:0]  csr_rdata_i,
   output id_bundle_t          bundle_o,
   output logic                uses_rs1_o,
   output logic                uses_rs2_o
);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [REG_AW-1:0] rd;
   logic              legal;
   logic              wr_rd;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];
   assign rd     = inst_i[11:7];

   // Per-opcode operand selection, legality and register usage.
   always_comb begin
      bundle_o            = '0;
      bundle_o.inst       = inst_i;
      bundle_o.inst_addr  = inst_addr_i;
      bundle_o.reg1_rdata = rs1_data_i;
      bundle_o.reg2_rdata = rs2_data_i;
      legal               = 1'b0;
      wr_rd               = 1'b0;
      uses_rs1_o          = 1'b0;
      uses_rs2_o          = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            if (funct3 == F3_SLL)     legal = (funct7 == F7_BASE);
            else if (funct3 == F3_SR) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else                      legal = 1'b1;
            uses_rs1_o   = 1'b1;
            wr_rd        = 1'b1;
            bundle_o.op1 = rs1_data_i;
            bundle_o.op2 = imm_gen(inst_i, IMM_I);
         end
         OPC_OP: begin
            case (funct7)
               F7_BASE:   legal = 1'b1;
               F7_ALT:    legal = (funct3 == F3_ADD) || (funct3 == F3_SR);
               F7_MULDIV: legal = ENABLE_M;
               default:   legal = 1'b0;
            endcase
            uses_rs1_o   = 1'b1;
            uses_rs2_o   = 1'b1;
            wr_rd        = 1'b1;
            bundle_o.op1 = rs1_data_i;
            bundle_o.op2 = rs2_data_i;
         end
         OPC_BRANCH: begin
            legal             = (funct3[2:1] != 2'b01);
            uses_rs1_o        = 1'b1;
            uses_rs2_o        = 1'b1;
            bundle_o.op1      = rs1_data_i;
            bundle_o.op2      = rs2_data_i;
            bundle_o.op1_jump = inst_addr_i;
            bundle_o.op2_jump = imm_gen(inst_i, IMM_B);
         end
         OPC_LOAD: begin
            legal        = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            uses_rs1_o   = 1'b1;
            wr_rd        = 1'b1;
            bundle_o.op1 = rs1_data_i;
            bundle_o.op2 = imm_gen(inst_i, IMM_I);
         end
         OPC_STORE: begin
            legal        = funct3 inside {3'b000, 3'b001, 3'b010};
            uses_rs1_o   = 1'b1;
            uses_rs2_o   = 1'b1;
            bundle_o.op1 = rs1_data_i;
            bundle_o.op2 = imm_gen(inst_i, IMM_S);
         end
         OPC_JAL: begin
            legal             = 1'b1;
            wr_rd             = 1'b1;
            bundle_o.op1      = inst_addr_i;
            bundle_o.op2      = RV_XLEN'(4);
            bundle_o.op1_jump = inst_addr_i;
            bundle_o.op2_jump = imm_gen(inst_i, IMM_J);
         end
         OPC_JALR: begin
            legal             = (funct3 == F3_JALR);
            uses_rs1_o        = 1'b1;
            wr_rd             = 1'b1;
            bundle_o.op1      = inst_addr_i;
            bundle_o.op2      = RV_XLEN'(4);
            bundle_o.op1_jump = rs1_data_i;
            bundle_o.op2_jump = imm_gen(inst_i, IMM_I);
         end
         OPC_LUI: begin
            legal        = 1'b1;
            wr_rd        = 1'b1;
            bundle_o.op1 = imm_gen(inst_i, IMM_U);
         end
         OPC_AUIPC: begin
            legal        = 1'b1;
            wr_rd        = 1'b1;
            bundle_o.op1 = inst_addr_i;
            bundle_o.op2 = imm_gen(inst_i, IMM_U);
         end
         OPC_FENCE: begin
            legal = funct3 inside {3'b000, 3'b001};
         end
         OPC_SYSTEM: begin
            // Only the CSR forms; funct3[2] selects the immediate (no rs1) variants.
            legal              = (funct3[1:0] != 2'b00);
            uses_rs1_o         = ~funct3[2];
            wr_rd              = 1'b1;
            bundle_o.csr_we    = 1'b1;
            bundle_o.csr_waddr = RV_XLEN'(inst_i[31:20]);
            bundle_o.csr_rdata = csr_rdata_i;
         end
         default: legal = 1'b0;
      endcase

      bundle_o.illegal = ~legal;
      if (legal) begin
         bundle_o.reg_we    = wr_rd & (rd != '0);
         bundle_o.reg_waddr = wr_rd ? rd : '0;
      end else begin
         bundle_o.op1       = '0;
         bundle_o.op2       = '0;
         bundle_o.op1_jump  = '0;
         bundle_o.op2_jump  = '0;
         bundle_o.csr_we    = 1'b0;
         bundle_o.csr_waddr = '0;
         bundle_o.csr_rdata = '0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// Registered, handshaked RV32I(M) decode stage with load-use stall, flush and WB forwarding.
module id_stage
   import rv_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter bit          ENABLE_M  = 1'b1,
   parameter bit          BYPASS_EN = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [31:0]       inst_i,
   input  logic [XLEN-1:0]   inst_addr_i,
   output logic [4:0]        reg1_raddr_o,
   output logic [4:0]        reg2_raddr_o,
   input  logic [XLEN-1:0]   reg1_rdata_i,
   input  logic [XLEN-1:0]   reg2_rdata_i,
   output logic [XLEN-1:0]   csr_raddr_o,
   input  logic [XLEN-1:0]   csr_rdata_i,
   input  logic              ex_jump_flag_i,
   input  logic              ex_load_pend_i,
   input  logic [4:0]        ex_load_rd_i,
   input  logic              fwd_we_i,
   input  logic [4:0]        fwd_waddr_i,
   input  logic [XLEN-1:0]   fwd_wdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   op1_o,
   output logic [XLEN-1:0]   op2_o,
   output logic [XLEN-1:0]   op1_jump_o,
   output logic [XLEN-1:0]   op2_jump_o,
   output logic [31:0]       inst_o,
   output logic [XLEN-1:0]   inst_addr_o,
   output logic [XLEN-1:0]   reg1_rdata_o,
   output logic [XLEN-1:0]   reg2_rdata_o,
   output logic              reg_we_o,
   output logic [4:0]        reg_waddr_o,
   output logic              csr_we_o,
   output logic [XLEN-1:0]   csr_rdata_o,
   output logic [XLEN-1:0]   csr_waddr_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   if (XLEN != 32) begin : g_xlen_chk
      $error("id_stage: only XLEN=32 is supported");
   end

   logic [REG_AW-1:0] rs1, rs2;
   logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
   logic              uses_rs1, uses_rs2;
   logic              hazard, accept, stall_inc;
   id_bundle_t        dec_bundle, bundle_q, bundle_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign rs1          = inst_i[19:15];
   assign rs2          = inst_i[24:20];
   assign reg1_raddr_o = rs1;
   assign reg2_raddr_o = rs2;
   assign csr_raddr_o  = (inst_i[6:0] == OPC_SYSTEM) ? XLEN'(inst_i[31:20]) : '0;

   // x0 reads as zero; otherwise a matching write-back overrides the regfile.
   always_comb begin
      rs1_fwd = reg1_rdata_i;
      rs2_fwd = reg2_rdata_i;
      if (rs1 == '0)                                            rs1_fwd = '0;
      else if (BYPASS_EN && fwd_we_i && (fwd_waddr_i == rs1))   rs1_fwd = fwd_wdata_i;
      if (rs2 == '0)                                            rs2_fwd = '0;
      else if (BYPASS_EN && fwd_we_i && (fwd_waddr_i == rs2))   rs2_fwd = fwd_wdata_i;
   end

   id_decode #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .inst_i      (inst_i),
      .inst_addr_i (inst_addr_i),
      .rs1_data_i  (rs1_fwd),
      .rs2_data_i  (rs2_fwd),
      .csr_rdata_i (csr_rdata_i),
      .bundle_o    (dec_bundle),
      .uses_rs1_o  (uses_rs1),
      .uses_rs2_o  (uses_rs2)
   );

   assign hazard    = ex_load_pend_i & (ex_load_rd_i != '0) &
                      ((uses_rs1 & (rs1 == ex_load_rd_i)) | (uses_rs2 & (rs2 == ex_load_rd_i)));
   assign in_ready_o = (~valid_q | out_ready_i) & ~hazard;
   assign accept    = in_valid_i & in_ready_o;
   assign stall_inc = in_valid_i & hazard & ~ex_jump_flag_i;

   // Next state: flush beats accept; consumption without accept leaves a bubble.
   always_comb begin
      valid_d  = valid_q;
      bundle_d = bundle_q;
      cnt_d    = cnt_q;
      if (ex_jump_flag_i) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec_bundle;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
      if (stall_inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   // Output register and stall counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q  <= 1'b0;
         bundle_q <= bundle_rst();
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid_o  = valid_q;
   assign op1_o        = bundle_q.op1;
   assign op2_o        = bundle_q.op2;
   assign op1_jump_o   = bundle_q.op1_jump;
   assign op2_jump_o   = bundle_q.op2_jump;
   assign inst_o       = bundle_q.inst;
   assign inst_addr_o  = bundle_q.inst_addr;
   assign reg1_rdata_o = bundle_q.reg1_rdata;
   assign reg2_rdata_o = bundle_q.reg2_rdata;
   assign reg_we_o     = bundle_q.reg_we;
   assign reg_waddr_o  = bundle_q.reg_waddr;
   assign csr_we_o     = bundle_q.csr_we;
   assign csr_rdata_o  = bundle_q.csr_rdata;
   assign csr_waddr_o  = bundle_q.csr_waddr;
   assign illegal_o    = bundle_q.illegal;
   assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: two instances (full-featured, and no-M/no-bypass/3-bit counter).
module tb_id_stage;

   typedef struct packed {
      logic [31:0] op1, op2, op1j, op2j, inst, pc, r1, r2, csr_rdata, csr_waddr;
      logic        reg_we;
      logic [4:0]  waddr;
      logic        csr_we;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, jmp, lp, fwe;
   logic [31:0] inst, pc_i, r1_i, r2_i, csr_i, fwd;
   logic [4:0]  lrd, fwa;

   logic        a_in_ready, a_valid, a_reg_we, a_csr_we, a_ill;
   logic [4:0]  a_r1a, a_r2a, a_waddr;
   logic [31:0] a_csr_raddr, a_op1, a_op2, a_op1j, a_op2j, a_inst, a_pc, a_r1, a_r2, a_csr_rd, a_csr_wa;
   logic [15:0] a_stall;
   logic        b_in_ready, b_valid, b_reg_we, b_csr_we, b_ill;
   logic [4:0]  b_r1a, b_r2a, b_waddr;
   logic [31:0] b_csr_raddr, b_op1, b_op2, b_op1j, b_op2j, b_inst, b_pc, b_r1, b_r2, b_csr_rd, b_csr_wa;
   logic [2:0]  b_stall;

   exp_t obs_a, obs_b;
   assign obs_a = {a_op1, a_op2, a_op1j, a_op2j, a_inst, a_pc, a_r1, a_r2, a_csr_rd, a_csr_wa,
                   a_reg_we, a_waddr, a_csr_we, a_ill};
   assign obs_b = {b_op1, b_op2, b_op1j, b_op2j, b_inst, b_pc, b_r1, b_r2, b_csr_rd, b_csr_wa,
                   b_reg_we, b_waddr, b_csr_we, b_ill};

   always #5 clk = ~clk;

   id_stage #(.XLEN(32), .ENABLE_M(1'b1), .BYPASS_EN(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready), .inst_i(inst),
      .inst_addr_i(pc_i), .reg1_raddr_o(a_r1a), .reg2_raddr_o(a_r2a), .reg1_rdata_i(r1_i),
      .reg2_rdata_i(r2_i), .csr_raddr_o(a_csr_raddr), .csr_rdata_i(csr_i), .ex_jump_flag_i(jmp),
      .ex_load_pend_i(lp), .ex_load_rd_i(lrd), .fwd_we_i(fwe), .fwd_waddr_i(fwa), .fwd_wdata_i(fwd),
      .out_valid_o(a_valid), .out_ready_i(out_ready), .op1_o(a_op1), .op2_o(a_op2),
      .op1_jump_o(a_op1j), .op2_jump_o(a_op2j), .inst_o(a_inst), .inst_addr_o(a_pc),
      .reg1_rdata_o(a_r1), .reg2_rdata_o(a_r2), .reg_we_o(a_reg_we), .reg_waddr_o(a_waddr),
      .csr_we_o(a_csr_we), .csr_rdata_o(a_csr_rd), .csr_waddr_o(a_csr_wa), .illegal_o(a_ill),
      .stall_cnt_o(a_stall));

   id_stage #(.XLEN(32), .ENABLE_M(1'b0), .BYPASS_EN(1'b0), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready), .inst_i(inst),
      .inst_addr_i(pc_i), .reg1_raddr_o(b_r1a), .reg2_raddr_o(b_r2a), .reg1_rdata_i(r1_i),
      .reg2_rdata_i(r2_i), .csr_raddr_o(b_csr_raddr), .csr_rdata_i(csr_i), .ex_jump_flag_i(jmp),
      .ex_load_pend_i(lp), .ex_load_rd_i(lrd), .fwd_we_i(fwe), .fwd_waddr_i(fwa), .fwd_wdata_i(fwd),
      .out_valid_o(b_valid), .out_ready_i(out_ready), .op1_o(b_op1), .op2_o(b_op2),
      .op1_jump_o(b_op1j), .op2_jump_o(b_op2j), .inst_o(b_inst), .inst_addr_o(b_pc),
      .reg1_rdata_o(b_r1), .reg2_rdata_o(b_r2), .reg_we_o(b_reg_we), .reg_waddr_o(b_waddr),
      .csr_we_o(b_csr_we), .csr_rdata_o(b_csr_rd), .csr_waddr_o(b_csr_wa), .illegal_o(b_ill),
      .stall_cnt_o(b_stall));

   int   n_chk = 0, n_pass = 0;
   exp_t q_a[$], q_b[$];
   bit   started = 0, occ = 0, m_fire = 0, m_flush = 0, m_consume = 0;
   int   cnt_a = 0, cnt_b = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic cmp(input string tag, input exp_t act, input exp_t e);
      chk({tag, ".op1"}, act.op1, e.op1);             chk({tag, ".op2"}, act.op2, e.op2);
      chk({tag, ".op1_jump"}, act.op1j, e.op1j);      chk({tag, ".op2_jump"}, act.op2j, e.op2j);
      chk({tag, ".inst"}, act.inst, e.inst);          chk({tag, ".inst_addr"}, act.pc, e.pc);
      chk({tag, ".reg1_rdata"}, act.r1, e.r1);        chk({tag, ".reg2_rdata"}, act.r2, e.r2);
      chk({tag, ".csr_rdata"}, act.csr_rdata, e.csr_rdata);
      chk({tag, ".csr_waddr"}, act.csr_waddr, e.csr_waddr);
      chk({tag, ".reg_we"}, 32'(act.reg_we), 32'(e.reg_we));
      chk({tag, ".reg_waddr"}, 32'(act.waddr), 32'(e.waddr));
      chk({tag, ".csr_we"}, 32'(act.csr_we), 32'(e.csr_we));
      chk({tag, ".illegal"}, 32'(act.ill), 32'(e.ill));
   endtask

   // Which source registers an instruction class reads.
   function automatic bit uses_rs(input logic [31:0] in, input int n);
      case (in[6:0])
         7'h33, 7'h63, 7'h23: return 1'b1;
         7'h13, 7'h03, 7'h67: return n == 1;
         7'h73:               return (n == 1) && (in[14:12] < 3'd4);
         default:             return 1'b0;
      endcase
   endfunction

   // Architectural legality of an RV32I(M) encoding.
   function automatic bit is_legal(input logic [31:0] in, input bit em);
      logic [2:0] f3 = in[14:12];
      logic [6:0] f7 = in[31:25];
      case (in[6:0])
         7'h13:        return !(f3 == 3'd1 && f7 != 7'h00) && !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         7'h33:        return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && em);
         7'h63:        return f3 != 3'd2 && f3 != 3'd3;
         7'h03:        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         7'h23:        return f3 <= 3'd2;
         7'h6F, 7'h37, 7'h17: return 1'b1;
         7'h67:        return f3 == 3'd0;
         7'h0F:        return f3 <= 3'd1;
         7'h73:        return f3 != 3'd0 && f3 != 3'd4;
         default:      return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] src_val(input logic [4:0] s, input logic [31:0] rf, input bit byp,
                                           input bit we, input logic [4:0] wa, input logic [31:0] wd);
      if (s == 5'd0) return 32'h0;
      if (byp && we && wa == s) return wd;
      return rf;
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] in, input logic [31:0] pc, r1d, r2d, csr,
                                       input bit em);
      exp_t e;
      bit   wr = 0;
      logic [31:0] ii = 32'($signed(in[31:20]));
      logic [31:0] si = 32'($signed({in[31:25], in[11:7]}));
      logic [31:0] bi = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
      logic [31:0] ji = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
      logic [31:0] ui = {in[31:12], 12'h000};
      e = '0; e.inst = in; e.pc = pc; e.r1 = r1d; e.r2 = r2d;
      case (in[6:0])
         7'h13: begin e.op1 = r1d; e.op2 = ii; wr = 1; end
         7'h33: begin e.op1 = r1d; e.op2 = r2d; wr = 1; end
         7'h63: begin e.op1 = r1d; e.op2 = r2d; e.op1j = pc; e.op2j = bi; end
         7'h03: begin e.op1 = r1d; e.op2 = ii; wr = 1; end
         7'h23: begin e.op1 = r1d; e.op2 = si; end
         7'h6F: begin e.op1 = pc; e.op2 = 4; e.op1j = pc; e.op2j = ji; wr = 1; end
         7'h67: begin e.op1 = pc; e.op2 = 4; e.op1j = r1d; e.op2j = ii; wr = 1; end
         7'h37: begin e.op1 = ui; wr = 1; end
         7'h17: begin e.op1 = pc; e.op2 = ui; wr = 1; end
         7'h73: begin e.csr_we = 1; e.csr_waddr = 32'(in[31:20]); e.csr_rdata = csr; wr = 1; end
         default: ;
      endcase
      if (is_legal(in, em)) begin
         e.reg_we = wr && (in[11:7] != 5'd0);
         e.waddr  = wr ? in[11:7] : 5'd0;
      end else begin
         e.op1 = 0; e.op2 = 0; e.op1j = 0; e.op2j = 0;
         e.csr_we = 0; e.csr_waddr = 0; e.csr_rdata = 0; e.ill = 1;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] in = $urandom;
      case ($urandom_range(0, 11))
         0: in[6:0] = 7'h13;  1: in[6:0] = 7'h33;  2: in[6:0] = 7'h63;  3: in[6:0] = 7'h03;
         4: in[6:0] = 7'h23;  5: in[6:0] = 7'h6F;  6: in[6:0] = 7'h67;  7: in[6:0] = 7'h37;
         8: in[6:0] = 7'h17;  9: in[6:0] = 7'h0F;  10: in[6:0] = 7'h73;
         default: in[6:0] = 7'($urandom);
      endcase
      in[11:7]  = 5'($urandom_range(0, 7));
      in[19:15] = 5'($urandom_range(0, 7));
      in[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
         0: in[31:25] = 7'h00;
         1: in[31:25] = 7'h20;
         2: in[31:25] = 7'h01;
         default: ;
      endcase
      return in;
   endfunction

   // One cycle of stimulus; predicts handshake, pushes expected bundles on accept.
   task automatic drive(input bit v, input logic [31:0] ins, input bit rdy, input bit jp,
                        input bit lpd, input logic [4:0] lrdv, input bit fwev, input logic [4:0] fwav,
                        input logic [31:0] fwdv, input logic [31:0] r1v, input logic [31:0] r2v);
      bit          hz, rexp, fire;
      logic [4:0]  s1, s2;
      logic [31:0] pcv, csv;
      @(posedge clk); #1;
      pcv = $urandom & 32'hFFFF_FFFC;
      csv = $urandom;
      in_valid = v; inst = ins; out_ready = rdy; jmp = jp; lp = lpd; lrd = lrdv;
      fwe = fwev; fwa = fwav; fwd = fwdv; r1_i = r1v; r2_i = r2v; pc_i = pcv; csr_i = csv;
      @(negedge clk);
      s1 = ins[19:15];
      s2 = ins[24:20];
      hz = lpd && (lrdv != 0) && ((uses_rs(ins, 1) && s1 == lrdv) || (uses_rs(ins, 2) && s2 == lrdv));
      rexp = (!occ || rdy) && !hz;
      chk("a.in_ready", 32'(a_in_ready), 32'(rexp));
      chk("b.in_ready", 32'(b_in_ready), 32'(rexp));
      chk("a.reg1_raddr", 32'(a_r1a), 32'(s1));
      chk("a.reg2_raddr", 32'(a_r2a), 32'(s2));
      chk("a.csr_raddr", a_csr_raddr, (ins[6:0] == 7'h73) ? 32'(ins[31:20]) : 32'h0);
      fire = v && rexp && !jp;
      if (fire) begin
         q_a.push_back(ref_decode(ins, pcv, src_val(s1, r1v, 1, fwev, fwav, fwdv),
                                  src_val(s2, r2v, 1, fwev, fwav, fwdv), csv, 1'b1));
         q_b.push_back(ref_decode(ins, pcv, src_val(s1, r1v, 0, fwev, fwav, fwdv),
                                  src_val(s2, r2v, 0, fwev, fwav, fwdv), csv, 1'b0));
      end
      m_fire = fire; m_flush = jp; m_consume = rdy;
      if (jp) occ = 0;
      else if (fire) occ = 1;
      else if (rdy) occ = 0;
      if (v && hz && !jp) begin
         if (cnt_a < 65535) cnt_a++;
         if (cnt_b < 7) cnt_b++;
      end
   endtask

   task automatic idle(input bit rdy);
      drive(0, 32'h00000013, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: new bundles are popped and compared; held bundles must stay stable.
   initial begin : monitor
      exp_t hold_a, hold_b;
      bit   hv = 0;
      forever begin
         @(posedge clk); #2;
         if (started) begin
            if (m_fire) begin
               chk("a.out_valid", 32'(a_valid), 1);
               chk("b.out_valid", 32'(b_valid), 1);
               if (q_a.size() == 0 || q_b.size() == 0) begin
                  chk("scoreboard_nonempty", 0, 1);
               end else begin
                  hold_a = q_a.pop_front();
                  hold_b = q_b.pop_front();
                  cmp("a", obs_a, hold_a);
                  cmp("b", obs_b, hold_b);
                  hv = 1;
               end
            end else if (m_flush || m_consume) begin
               chk("a.out_valid", 32'(a_valid), 0);
               chk("b.out_valid", 32'(b_valid), 0);
               hv = 0;
            end else begin
               chk("a.out_valid_hold", 32'(a_valid), 32'(hv));
               chk("b.out_valid_hold", 32'(b_valid), 32'(hv));
               if (hv) begin
                  cmp("a_hold", obs_a, hold_a);
                  cmp("b_hold", obs_b, hold_b);
               end
            end
            chk("a.stall_cnt", 32'(a_stall), 32'(cnt_a));
            chk("b.stall_cnt", 32'(b_stall), 32'(cnt_b));
         end
      end
   end

   initial begin : stimulus
      exp_t rst_e;
      rst = 0; in_valid = 0; inst = 32'h13; out_ready = 0; jmp = 0; lp = 0; lrd = 0;
      fwe = 0; fwa = 0; fwd = 0; r1_i = 0; r2_i = 0; pc_i = 0; csr_i = 0;
      repeat (3) @(posedge clk);
      #2;
      rst_e = '0;
      rst_e.inst = 32'h00000013;
      cmp("rst_a", obs_a, rst_e);
      cmp("rst_b", obs_b, rst_e);
      chk("rst_a.out_valid", 32'(a_valid), 0);
      chk("rst_b.out_valid", 32'(b_valid), 0);
      chk("rst_a.stall_cnt", 32'(a_stall), 0);
      chk("rst_b.stall_cnt", 32'(b_stall), 0);
      @(negedge clk);
      rst = 1;
      started = 1;

      // ADDI x1,x0,5
      drive(1, 32'h00500093, 1, 0, 0, 0, 0, 0, 0, $urandom, $urandom);
      idle(1);
      // ADD x4,x3,x2 behind a load to x3, then the load retires
      drive(1, 32'h00218233, 1, 0, 1, 5'd3, 0, 0, 0, 32'h33, 32'h22);
      drive(1, 32'h00218233, 1, 0, 0, 5'd3, 0, 0, 0, 32'h33, 32'h22);
      // ADD x5,x6,x0 with write-back forwarding of x6
      drive(1, 32'h000302B3, 1, 0, 0, 0, 1, 5'd6, 32'hAA, 32'h11, 32'h99);
      // accept attempt coincident with a flush
      drive(1, 32'h00100393, 1, 1, 0, 0, 0, 0, 0, 1, 2);
      idle(1);
      // backpressure for three cycles, then release
      drive(1, 32'h00C58513, 1, 0, 0, 0, 0, 0, 0, 7, 8);
      repeat (3) drive(1, 32'h40B50533, 0, 0, 0, 0, 0, 0, 0, 3, 4);
      drive(1, 32'h40B50533, 1, 0, 0, 0, 0, 0, 0, 3, 4);
      // MUL x1,x2,x3
      drive(1, 32'h023100B3, 1, 0, 0, 0, 0, 0, 0, 5, 6);
      idle(1);

      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      end
      repeat (2) idle(1);
      @(posedge clk); #3;
      chk("scoreboard_drained_a", 32'(q_a.size()), 0);
      chk("scoreboard_drained_b", 32'(q_b.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
